// File: rtl/qcw_ocd_multi.sv
// Multi-channel QCW overcurrent detector: filtered per-channel trip latches driving qcw_halt,
// with peak-hold and raw readback on a picorv-style memory bus.
module qcw_ocd_multi #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADC_WIDTH  = 10,
  parameter int unsigned ADC_MID    = 512,
  parameter int unsigned FILT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_valid_i,
  output logic                          mem_ready_o,
  input  logic [31:0]                   mem_addr_i,
  input  logic [31:0]                   mem_wdata_i,
  input  logic [3:0]                    mem_wstrb_i,
  output logic [31:0]                   mem_rdata_o,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_dout,
  input  logic                          qcw_start,
  output logic                          qcw_halt
);

  localparam logic [ADC_WIDTH-1:0]  Mid    = ADC_MID[ADC_WIDTH-1:0];
  localparam logic [31:0]           Span   = 32'h20 + 32'(16 * NUM_CH);
  localparam logic [FILT_WIDTH-1:0] CntMax = '1;

  logic [ADC_WIDTH-1:0]  raw_q   [NUM_CH];
  logic [ADC_WIDTH-1:0]  abs_q   [NUM_CH];
  logic [ADC_WIDTH-1:0]  abs_d   [NUM_CH];
  logic [ADC_WIDTH-1:0]  limit_q [NUM_CH];
  logic [ADC_WIDTH-1:0]  peak_q  [NUM_CH];
  logic [FILT_WIDTH-1:0] cnt_q   [NUM_CH];
  logic [FILT_WIDTH-1:0] cnt_d   [NUM_CH];
  logic [FILT_WIDTH:0]   cnt_p1  [NUM_CH];

  logic [NUM_CH-1:0]     trip_q, trip_d, trip_set, status_clr, over;
  logic [NUM_CH-1:0]     mask_q, limit_we, peak_clr;
  logic                  en_q;
  logic [FILT_WIDTH-1:0] filt_q;
  logic [FILT_WIDTH:0]   filt_eff;
  logic                  proc_q, start_q, start_rise;

  logic [31:0] off, rd_val, ctrl_rd;
  logic        addressed, first, wr, ctrl_we, status_we, filt_we;
  logic        unused_wdata;

  assign unused_wdata = ^mem_wdata_i;

  // Bus decode; offset arithmetic also rejects addresses below the base via wrap-around.
  always_comb begin
    off       = mem_addr_i - BASE_ADDR;
    addressed = mem_valid_i && (off < Span);
    first     = addressed && !proc_q;
    wr        = first && (mem_wstrb_i != 4'b0);
    ctrl_we   = wr && (off[31:2] == 30'd0);
    status_we = wr && (off[31:2] == 30'd1);
    filt_we   = wr && (off[31:2] == 30'd2);

    ctrl_rd              = '0;
    ctrl_rd[0]           = en_q;
    ctrl_rd[8 +: NUM_CH] = mask_q;

    rd_val = '0;
    if (off[31:2] == 30'd0) rd_val = ctrl_rd;
    if (off[31:2] == 30'd1) rd_val = 32'(trip_q);
    if (off[31:2] == 30'd2) rd_val = 32'(filt_q);

    limit_we = '0;
    peak_clr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (off[31:4] == 28'(c + 2)) begin
        limit_we[c] = wr && (off[3:2] == 2'd0);
        peak_clr[c] = wr && (off[3:2] == 2'd1);
        case (off[3:2])
          2'd0:    rd_val = 32'(limit_q[c]);
          2'd1:    rd_val = 32'(peak_q[c]);
          2'd2:    rd_val = 32'(raw_q[c]);
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Filter and trip evaluation on the registered deviation.
  always_comb begin
    filt_eff   = (filt_q == '0) ? (FILT_WIDTH + 1)'(1) : {1'b0, filt_q};
    status_clr = status_we ? mem_wdata_i[NUM_CH-1:0] : '0;
    start_rise = qcw_start && !start_q;
    over       = '0;
    trip_set   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      abs_d[c]  = (raw_q[c] > Mid) ? raw_q[c] - Mid : Mid - raw_q[c];
      over[c]   = abs_q[c] >= limit_q[c];
      cnt_p1[c] = {1'b0, cnt_q[c]} + (FILT_WIDTH + 1)'(1);
      cnt_d[c]  = '0;
      if (over[c] && !mask_q[c]) begin
        cnt_d[c] = cnt_p1[c][FILT_WIDTH] ? CntMax : cnt_p1[c][FILT_WIDTH-1:0];
      end
      trip_set[c] = over[c] && !mask_q[c] && en_q && (cnt_p1[c] >= filt_eff);
    end
    // A trip being set wins over a simultaneous software clear.
    trip_d = (trip_q & ~status_clr) | trip_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_q      <= 1'b0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      start_q     <= 1'b0;
      trip_q      <= '0;
      qcw_halt    <= 1'b0;
      en_q        <= 1'b1;
      mask_q      <= '0;
      filt_q      <= FILT_WIDTH'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        raw_q[c]   <= '0;
        abs_q[c]   <= '0;
        cnt_q[c]   <= '0;
        limit_q[c] <= '1;
        peak_q[c]  <= '0;
      end
    end else begin
      proc_q      <= addressed;
      mem_ready_o <= first;
      mem_rdata_o <= first ? rd_val : '0;
      start_q     <= qcw_start;
      trip_q      <= trip_d;
      qcw_halt    <= |trip_d;
      if (ctrl_we) begin
        en_q   <= mem_wdata_i[0];
        mask_q <= mem_wdata_i[8 +: NUM_CH];
      end
      if (filt_we) filt_q <= mem_wdata_i[FILT_WIDTH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        raw_q[c] <= adc_dout[c*ADC_WIDTH +: ADC_WIDTH];
        abs_q[c] <= abs_d[c];
        cnt_q[c] <= cnt_d[c];
        if (limit_we[c]) limit_q[c] <= mem_wdata_i[ADC_WIDTH-1:0];
        // Pulse start and software clear both beat a same-cycle peak capture.
        if (start_rise || peak_clr[c]) peak_q[c] <= '0;
        else if (abs_q[c] > peak_q[c]) peak_q[c] <= abs_q[c];
      end
    end
  end

endmodule

// File: tb/tb_qcw_ocd_multi.sv
// Self-checking bench for qcw_ocd_multi: behavioural model plus bus-read scoreboard.
module tb_qcw_ocd_multi;
  localparam int NCH = 2;
  localparam int AW  = 10;
  localparam int MID = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_valid, mem_ready;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;
  logic [NCH*AW-1:0] adc_dout;
  logic              qcw_start, qcw_halt;
  int                samp [NCH];

  always #5 clk = ~clk;

  always_comb begin
    adc_dout = '0;
    for (int c = 0; c < NCH; c++) adc_dout[c*AW +: AW] = AW'(samp[c]);
  end

  qcw_ocd_multi dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid_i(mem_valid),
    .mem_ready_o(mem_ready),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb),
    .mem_rdata_o(mem_rdata),
    .adc_dout   (adc_dout),
    .qcw_start  (qcw_start),
    .qcw_halt   (qcw_halt)
  );

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];

  // Reference model state: what software and the analog side should observe.
  bit           m_en, m_proc, m_start, m_halt;
  bit [NCH-1:0] m_mask, m_trip;
  int           m_filt;
  int           m_limit [NCH];
  int           m_peak [NCH];
  int           m_run [NCH];
  int           m_raw [NCH];
  int           m_pend [NCH][2];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int absdev(int s);
    return (s > MID) ? s - MID : MID - s;
  endfunction

  function automatic void model_reset();
    m_en = 1; m_proc = 0; m_start = 0; m_halt = 0;
    m_mask = '0; m_trip = '0; m_filt = 1;
    for (int c = 0; c < NCH; c++) begin
      m_limit[c] = (1 << AW) - 1;
      m_peak[c] = 0; m_run[c] = 0; m_raw[c] = 0;
      m_pend[c][0] = 0;          // deviation register after reset
      m_pend[c][1] = absdev(0);  // deviation of the reset raw sample
    end
    exp_q.delete();
    addr_q.delete();
  endfunction

  function automatic logic [31:0] rd_model(logic [31:0] off);
    int o, c, r;
    o = int'(off & ~32'd3);
    if (o == 0) return {22'b0, m_mask, 7'b0, m_en};
    if (o == 4) return 32'(m_trip);
    if (o == 8) return 32'(m_filt);
    if (o < 32) return 32'd0;
    c = (o - 32) / 16;
    r = (o - 32) % 16;
    if (r == 0) return 32'(m_limit[c]);
    if (r == 4) return 32'(m_peak[c]);
    if (r == 8) return 32'(m_raw[c]);
    return 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs that were presented at it.
  function automatic void model_edge();
    logic [31:0]  off;
    bit           addressed, first, we, rise, over, pclr;
    bit [NCH-1:0] set, clr;
    int           e, eff, o;
    off       = mem_addr;
    addressed = mem_valid && (off < 32'(32 + 16 * NCH));
    first     = addressed && !m_proc;
    m_proc    = addressed;
    we        = first && (mem_wstrb != 4'b0);
    o         = int'(off & ~32'd3);
    if (first) begin
      exp_q.push_back(rd_model(off));
      addr_q.push_back(off);
    end
    rise    = qcw_start && !m_start;
    m_start = qcw_start;
    clr     = (we && o == 4) ? mem_wdata[NCH-1:0] : '0;
    eff     = (m_filt == 0) ? 1 : m_filt;
    set     = '0;
    for (int c = 0; c < NCH; c++) begin
      e = m_pend[c][0];
      m_pend[c][0] = m_pend[c][1];
      m_pend[c][1] = absdev(samp[c]);
      m_raw[c] = samp[c];
      over = e >= m_limit[c];
      if (m_mask[c] || !over) m_run[c] = 0;
      else if (m_run[c] < 15) m_run[c]++;
      set[c] = over && !m_mask[c] && m_en && (m_run[c] >= eff);
      pclr = we && (o == 36 + 16 * c);
      if (rise || pclr) m_peak[c] = 0;
      else if (e > m_peak[c]) m_peak[c] = e;
      if (we && o == 32 + 16 * c) m_limit[c] = int'(mem_wdata[AW-1:0]);
    end
    m_trip = (m_trip & ~clr) | set;
    m_halt = |m_trip;
    if (we && o == 0) begin
      m_en = mem_wdata[0];
      m_mask = mem_wdata[8 +: NCH];
    end
    if (we && o == 8) m_filt = int'(mem_wdata[3:0]);
  endfunction

  // Monitor: halt every cycle, bus responses against the scoreboard.
  always @(negedge clk) begin
    check("qcw_halt", {31'b0, qcw_halt}, {31'b0, m_halt});
    if (mem_ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_ready actual=1 required=0 rdata=0x%0h at %0t", mem_rdata, $time);
      end else begin
        check($sformatf("rdata@0x%0h", addr_q.pop_front()), mem_rdata, exp_q.pop_front());
      end
    end else begin
      check("rdata_idle", mem_rdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic bus_rd(logic [31:0] a);
    mem_valid = 1; mem_addr = a; mem_wstrb = 4'h0;
    tick();
    mem_valid = 0;
    tick();
  endtask

  task automatic bus_wr(logic [31:0] a, logic [31:0] d);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = 4'hF;
    tick();
    mem_valid = 0; mem_wstrb = 4'h0;
    tick();
  endtask

  task automatic set_all(int v);
    for (int c = 0; c < NCH; c++) samp[c] = v;
  endtask

  initial begin
    reset = 1; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; qcw_start = 0;
    set_all(MID);
    model_reset();
    ticks(2);
    reset = 0;

    // Reset values and single-sample trip threshold.
    bus_rd(32'h00); bus_rd(32'h08); bus_rd(32'h20); bus_rd(32'h30); bus_rd(32'h04);
    bus_wr(32'h20, 100);
    bus_wr(32'h08, 1);
    samp[0] = 612; tick(); samp[0] = MID; ticks(4);
    bus_rd(32'h04);
    bus_wr(32'h04, 32'h1); ticks(2);
    samp[0] = 611; tick(); samp[0] = MID; ticks(4);
    bus_rd(32'h04);

    // Consecutive-sample filter, interrupted run.
    bus_wr(32'h08, 3);
    bus_wr(32'h30, 50);
    foreach (samp[i]) samp[i] = MID;
    begin
      int seq [6] = '{600, 600, 500, 600, 600, 600};
      foreach (seq[i]) begin samp[1] = seq[i]; tick(); end
    end
    samp[1] = MID; ticks(4);
    bus_rd(32'h04);

    // Clear ordering and set-beats-clear.
    bus_wr(32'h08, 1);
    set_all(700); tick(); set_all(MID); ticks(4);
    bus_wr(32'h04, 32'h1); bus_rd(32'h04);
    bus_wr(32'h04, 32'h2); ticks(2); bus_rd(32'h04);
    samp[0] = 700; ticks(4);
    bus_wr(32'h04, 32'h1); bus_rd(32'h04);
    samp[0] = MID; ticks(4);
    bus_wr(32'h04, 32'h3); ticks(2);

    // Channel mask and global disable.
    bus_wr(32'h00, 32'h0101);
    bus_wr(32'h24, 0);
    samp[0] = 1023; ticks(5); samp[0] = MID; ticks(3);
    bus_rd(32'h24); bus_rd(32'h04);
    bus_wr(32'h00, 32'h0);
    set_all(1023); ticks(5); set_all(MID); ticks(3);
    bus_rd(32'h04); bus_rd(32'h00);
    bus_wr(32'h00, 32'h1);

    // Peak capture, clear on pulse start, and collision with a peak read.
    bus_wr(32'h24, 0); ticks(3);
    samp[0] = 812; tick(); samp[0] = MID; ticks(4);
    bus_rd(32'h24); bus_rd(32'h28);
    qcw_start = 1; mem_valid = 1; mem_addr = 32'h24; tick(); mem_valid = 0; tick();
    qcw_start = 0; ticks(2);
    bus_rd(32'h24);

    // Held request acknowledges once; unmapped offset reads zero and ignores writes.
    ready_cnt = 0;
    mem_valid = 1; mem_addr = 32'h00; ticks(5); mem_valid = 0; ticks(2);
    check("ready_once", 32'(ready_cnt), 32'd1);
    bus_wr(32'h10, 32'hFFFF_FFFF); bus_rd(32'h10); bus_rd(32'h3C);

    // Randomised traffic.
    bus_wr(32'h20, 100); bus_wr(32'h30, 120);
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < NCH; c++) samp[c] = MID - 170 + int'($urandom_range(0, 340));
      if ($urandom_range(0, 7) == 0) qcw_start = ~qcw_start;
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_addr  = ($urandom_range(0, 9) == 0) ? 32'h40 + 4 * $urandom_range(0, 3)
                                               : 4 * $urandom_range(0, 15);
      mem_wstrb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      mem_wdata = $urandom;
      if (mem_addr == 32'h00) mem_wdata[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    mem_valid = 0; mem_wstrb = 0; qcw_start = 0; set_all(MID); ticks(4);

    // Asynchronous reset while tripped, with a read response on the bus.
    bus_wr(32'h00, 32'h1); bus_wr(32'h08, 1); bus_wr(32'h20, 100);
    samp[0] = 700; ticks(4);
    check("halt_before_reset", {31'b0, qcw_halt}, 32'd1);
    mem_valid = 1; mem_addr = 32'h04; tick(); mem_valid = 0;
    #1 reset = 1;
    model_reset();
    #1;
    check("async_halt", {31'b0, qcw_halt}, 32'd0);
    check("async_ready", {31'b0, mem_ready}, 32'd0);
    check("async_rdata", mem_rdata, 32'd0);
    samp[0] = MID;
    ticks(2);
    reset = 0;
    bus_rd(32'h04); bus_rd(32'h20); bus_rd(32'h30);
    ticks(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_ready actual=%0d_pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qcw_ocd_multi.md
Name: qcw_ocd_multi

Overview:
- Parametrised, multi-channel successor to the single-channel QCW overcurrent detector.
- Monitors NUM_CH bipolar ADC current channels and takes the absolute deviation of each from mid-scale.
- Trips a per-channel latch when the deviation stays at or above a per-channel limit for a programmable number of consecutive samples. Any trip drives qcw_halt to the QCW pulse sequencer.
- Also keeps per-channel peak-hold and raw readback on the picorv-style memory bus. Peaks auto-clear at the start of each QCW pulse.

Parameters:
- BASE_ADDR, 32'h00000000, bus base address.
- NUM_CH, 2, number of ADC channels (1..8).
- ADC_WIDTH, 10, ADC sample width (8..16).
- ADC_MID, 512, mid-scale code subtracted before abs; must be < 2^ADC_WIDTH.
- FILT_WIDTH, 4, width of the consecutive-sample filter counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mem_valid_i  in  1  bus request valid.
- mem_ready_o  out  1  bus acknowledge, one-cycle pulse.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; nonzero means write.
- mem_rdata_o  out  32  read data; zero when not acknowledging.
- adc_dout  in  NUM_CH*ADC_WIDTH  raw samples; channel c occupies bits [c*ADC_WIDTH +: ADC_WIDTH].
- qcw_start  in  1  high during a QCW pulse request.
- qcw_halt  out  1  high while any enabled channel trip is latched.

Behaviour:
- Reset is asynchronous. All outputs are 0.
- All trip latches, filter counters, peaks and pipeline registers reset to 0.
- Limits reset to all-ones, so nothing can trip before software programs a limit.
- CTRL resets to 0x1 (global enable on, channel mask 0 = all channels enabled).
- FILT resets to 1.
- Pipeline, per channel:
  - Edge 1 registers the raw sample.
  - Edge 2 registers abs = (raw > ADC_MID) ? raw - ADC_MID : ADC_MID - raw, ADC_WIDTH bits, no overflow possible.
  - Edge 3 evaluates the filter and trip.
  - With FILT=1, qcw_halt rises on the 3rd edge after an over-limit sample is presented.
- Filter:
  - over = (abs >= limit). If over, cnt <= sat(cnt+1); else cnt <= 0.
  - Trip sets when over and cnt+1 >= FILT; FILT=0 is treated as 1. The counter saturates at 2^FILT_WIDTH-1.
  - Trip latch is sticky. qcw_halt is registered and computed from the next-state trip vector, so it rises on the same edge the trip sets.
  - A channel whose CTRL[8+c] mask bit is 1 never trips. Its counter is held at 0.
  - Global enable CTRL[0]=0 suppresses new trips. Existing latches are kept.
- Peak: if abs > peak, then peak <= abs, for all channels regardless of mask.
  - A rising edge of qcw_start (detected with a 1-cycle registered copy) clears every peak to 0 on that edge. The abs sample from the same cycle is not captured.
- Bus:
  - transaction_processed <= device_addressed each cycle. Addressed means mem_valid_i and BASE_ADDR <= addr < BASE_ADDR + 0x20 + 16*NUM_CH.
  - On the first cycle addressed, mem_ready_o <= 1 for exactly one cycle and mem_rdata_o <= register value; otherwise both are 0.
  - Word-aligned decode only; strobes are all-or-nothing.
  - Unmapped in-range addresses read 0 and ignore writes.
- Register map (byte offsets):
  - 0x00 CTRL RW: [0] enable, [8+c] channel mask.
  - 0x04 STATUS: read returns {24'b0, trip vector}. A write clears the trip bits whose wdata bit is 1.
  - 0x08 FILT RW: [FILT_WIDTH-1:0].
  - 0x20+16c LIMIT RW: [ADC_WIDTH-1:0].
  - 0x24+16c PEAK: read returns the peak, zero-extended; any write clears it.
  - 0x28+16c RAW R: registered raw sample.
- Collisions:
  - Trip set and STATUS write-clear in the same cycle: set wins, bit stays 1.
  - Peak update and write-clear in the same cycle: the clear wins.
  - qcw_start rising edge together with a PEAK read: the read returns the pre-clear value.
- qcw_halt stays high until every trip bit is cleared; it falls on the edge after the last clear.

Test Plan:
- Reset, then LIMIT0=100 and FILT=1. Drive ch0 code 612 (abs 100) -> STATUS=0x1, qcw_halt high exactly 3 edges after the sample is presented. Ch0 code 611 alone -> no trip.
- FILT=3, ch1 LIMIT=50, ch1 codes 600,600,500,600,600,600 -> trip only on the 3rd consecutive over-limit sample, i.e. the 6th sample. The 500 sample resets the count.
- Trip ch0 and ch1, write STATUS 0x1 -> STATUS=0x2 and halt stays high. Write 0x2 -> halt low on the next edge. Write 0x1 in the same cycle ch0 is over -> bit 0 remains set.
- CTRL=0x0101 (ch0 masked), ch0 code 1023 -> no trip and halt low; PEAK0 reads 511. CTRL=0 -> no new trips on any channel.
- Ch0 peak 300 captured, pulse qcw_start 0->1 -> PEAK0 reads 0 afterward. Read a mapped register -> mem_ready_o high exactly one cycle even with mem_valid_i held 5 cycles. Read unmapped offset 0x10 -> 0.
- Assert reset mid-trip with halt high -> qcw_halt, mem_ready_o and STATUS go to 0 immediately, without waiting for a clock edge. LIMITs read back all-ones.
